// File: rtl/product_accumulator.sv
// Temporal K-reduction of multiplier product tiles into saturating unsigned lane sums,
// with a single held output tile on a valid/ready port.
module product_accumulator #(
  parameter int unsigned DIM_A     = 16,
  parameter int unsigned DIM_C     = 4,
  parameter int unsigned ACC_WIDTH = 12,
  parameter int unsigned SUM_WIDTH = 20,
  parameter int unsigned LEN_W     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0] prod,
  input  logic                             prod_valid,
  output logic                             prod_ready,
  input  logic [LEN_W-1:0]                 acc_len,
  output logic [DIM_C*DIM_A*SUM_WIDTH-1:0] sum,
  output logic                             sum_valid,
  input  logic                             sum_ready,
  output logic                             overflow
);

  localparam int unsigned LANES = DIM_C * DIM_A;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [LEN_W-1:0]             count;
  logic [LEN_W-1:0]             count_inc;
  logic [LEN_W-1:0]             len_q;
  logic [LEN_W-1:0]             eff_len;
  logic                         accept;
  logic                         start_group;
  logic [LANES*SUM_WIDTH-1:0]   sum_next;
  logic [LANES-1:0]             lane_sat;
  logic [SUM_WIDTH:0]           wide;

  assign prod_ready  = !rst && ((state != HOLD) || sum_ready);
  assign accept      = prod_valid && prod_ready;
  // In HOLD an accept implies sum_ready, so the held tile leaves on the same edge.
  assign start_group = accept && (state != ACCUM);
  assign eff_len     = (acc_len == '0) ? LEN_W'(1) : acc_len;
  assign count_inc   = count + LEN_W'(1);

  always_comb begin
    sum_next = '0;
    lane_sat = '0;
    wide     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wide = {1'b0, sum[i*SUM_WIDTH +: SUM_WIDTH]} +
             (SUM_WIDTH+1)'(prod[i*ACC_WIDTH +: ACC_WIDTH]);
      if (start_group) begin
        sum_next[i*SUM_WIDTH +: SUM_WIDTH] = SUM_WIDTH'(prod[i*ACC_WIDTH +: ACC_WIDTH]);
      end else if (wide[SUM_WIDTH]) begin
        sum_next[i*SUM_WIDTH +: SUM_WIDTH] = '1;
        lane_sat[i]                        = 1'b1;
      end else begin
        sum_next[i*SUM_WIDTH +: SUM_WIDTH] = wide[SUM_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = (eff_len == LEN_W'(1)) ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (accept && (count_inc == len_q)) state_next = HOLD;
      end
      HOLD: begin
        if (accept)         state_next = (eff_len == LEN_W'(1)) ? HOLD : ACCUM;
        else if (sum_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sum       <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      len_q     <= '0;
    end else begin
      state     <= state_next;
      sum_valid <= (state_next == HOLD);
      if (start_group) begin
        sum      <= sum_next;
        overflow <= 1'b0;
        count    <= LEN_W'(1);
        len_q    <= eff_len;
      end else if (accept) begin
        sum      <= sum_next;
        overflow <= overflow | (|lane_sat);
        count    <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 20-bit and a 16-bit sum build driven in lockstep,
// vector table plus hand sequences, scoreboard checked at each output transfer.
module tb_product_accumulator;

  localparam int unsigned LANES = 64;
  localparam int unsigned PW    = LANES * 12;
  localparam int unsigned S20   = LANES * 20;
  localparam int unsigned S16   = LANES * 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [PW-1:0]  prod;
  logic           prod_valid;
  logic           prod_ready;
  logic           prod_ready16;
  logic [7:0]     acc_len;
  logic [S20-1:0] sum20;
  logic [S16-1:0] sum16;
  logic           sum_valid;
  logic           sum_valid16;
  logic           sum_ready;
  logic           overflow;
  logic           overflow16;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    logic [S20-1:0] s20;
    logic           o20;
    logic [S16-1:0] s16;
    logic           o16;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [7:0]  len_prog;
    int unsigned beats;
    logic [11:0] val;
    int unsigned e20;
    logic        o20;
    int unsigned e16;
    logic        o16;
  } vec_t;

  vec_t tbl[8];

  product_accumulator #(.DIM_A(16), .DIM_C(4), .ACC_WIDTH(12), .SUM_WIDTH(20), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_len(acc_len), .sum(sum20), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .overflow(overflow)
  );

  product_accumulator #(.DIM_A(16), .DIM_C(4), .ACC_WIDTH(12), .SUM_WIDTH(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready16),
    .acc_len(acc_len), .sum(sum16), .sum_valid(sum_valid16), .sum_ready(sum_ready),
    .overflow(overflow16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] tile_p(input logic [11:0] v);
    logic [PW-1:0] t;
    for (int i = 0; i < LANES; i++) t[i*12 +: 12] = v;
    return t;
  endfunction

  function automatic logic [S20-1:0] tile_20(input int unsigned v);
    logic [S20-1:0] t;
    for (int i = 0; i < LANES; i++) t[i*20 +: 20] = v[19:0];
    return t;
  endfunction

  function automatic logic [S16-1:0] tile_16(input int unsigned v);
    logic [S16-1:0] t;
    for (int i = 0; i < LANES; i++) t[i*16 +: 16] = v[15:0];
    return t;
  endfunction

  function automatic exp_t mk_exp(input int unsigned v20, input logic o20,
                                  input int unsigned v16, input logic o16);
    exp_t e;
    e.s20 = tile_20(v20);
    e.o20 = o20;
    e.s16 = tile_16(v16);
    e.o16 = o16;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) $display("FAIL %s: got %0h, expected %0h", name, got, want);
    else passes++;
  endtask

  // Scoreboard: compare both builds whenever a tile leaves the 20-bit instance.
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      exp_t e;
      int   bad;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: output beat with lane0=%0d, no group expected", sum20[19:0]);
      end else begin
        e   = sb.pop_front();
        bad = -1;
        for (int i = LANES - 1; i >= 0; i--)
          if (sum20[i*20 +: 20] !== e.s20[i*20 +: 20] || sum16[i*16 +: 16] !== e.s16[i*16 +: 16])
            bad = i;
        if (bad >= 0)
          $display("FAIL sb_sum lane %0d: got %0d/%0d, expected %0d/%0d (20b/16b)", bad,
                   sum20[bad*20 +: 20], sum16[bad*16 +: 16], e.s20[bad*20 +: 20], e.s16[bad*16 +: 16]);
        else if (overflow !== e.o20 || overflow16 !== e.o16 || sum_valid16 !== 1'b1)
          $display("FAIL sb_ovf: got %b/%b valid16 %b, expected %b/%b valid16 1",
                   overflow, overflow16, sum_valid16, e.o20, e.o16);
        else passes++;
      end
    end
  end

  task automatic beat(input logic [PW-1:0] p, input logic [7:0] len);
    int n;
    bit done;
    n          = 0;
    done       = 1'b0;
    prod       = p;
    acc_len    = len;
    prod_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (prod_ready) begin
        done = 1'b1;
      end else if (n >= 200) begin
        checks++;
        $display("FAIL beat_accept: prod_ready stayed %b for %0d cycles, expected 1", prod_ready, n);
        done = 1'b1;
      end
      n++;
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL %s: %0d groups outstanding, expected 0", name, sb.size());
    else passes++;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [PW-1:0]  t;
    logic [S20-1:0] ea20;
    logic [S16-1:0] ea16;
    exp_t           e;
    int             t0;
    logic [11:0]    lane_vals[4];

    tbl[0] = '{len_prog: 8'd1,   beats: 1,   val: 12'hFFF, e20: 4095,    o20: 1'b0, e16: 4095,  o16: 1'b0};
    tbl[1] = '{len_prog: 8'd0,   beats: 1,   val: 12'd7,   e20: 7,       o20: 1'b0, e16: 7,     o16: 1'b0};
    tbl[2] = '{len_prog: 8'd3,   beats: 3,   val: 12'd100, e20: 300,     o20: 1'b0, e16: 300,   o16: 1'b0};
    tbl[3] = '{len_prog: 8'd255, beats: 255, val: 12'hFFF, e20: 1044225, o20: 1'b0, e16: 65535, o16: 1'b1};
    tbl[4] = '{len_prog: 8'd1,   beats: 1,   val: 12'd1,   e20: 1,       o20: 1'b0, e16: 1,     o16: 1'b0};
    tbl[5] = '{len_prog: 8'd16,  beats: 16,  val: 12'hFFF, e20: 65520,   o20: 1'b0, e16: 65520, o16: 1'b0};
    tbl[6] = '{len_prog: 8'd17,  beats: 17,  val: 12'hFFF, e20: 69615,   o20: 1'b0, e16: 65535, o16: 1'b1};
    tbl[7] = '{len_prog: 8'd2,   beats: 2,   val: 12'd0,   e20: 0,       o20: 1'b0, e16: 0,     o16: 1'b0};

    rst        = 1'b1;
    prod       = '0;
    prod_valid = 1'b0;
    acc_len    = 8'd0;
    sum_ready  = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_prod_ready", {31'b0, prod_ready}, 32'd0);
    chk("rst_prod_ready16", {31'b0, prod_ready16}, 32'd0);
    chk("rst_sum_valid", {31'b0, sum_valid}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_sum_zero", {31'b0, (sum20 === '0) && (sum16 === '0)}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_prod_ready", {31'b0, prod_ready}, 32'd1);
    @(posedge clk); #1;

    // Vector table, streamed with sum_ready high; acc_len scrambled after the first beat
    sum_ready = 1'b1;
    foreach (tbl[k]) begin
      sb.push_back(mk_exp(tbl[k].e20, tbl[k].o20, tbl[k].e16, tbl[k].o16));
      for (int b = 0; b < int'(tbl[k].beats); b++)
        beat(tile_p(tbl[k].val), (b == 0) ? tbl[k].len_prog : 8'd1);
    end
    drain("table_drain");

    // L=4 with bubbles, lane (c=1,a=3) gets 5,10,0,7; output held by back-pressure
    sum_ready    = 1'b0;
    lane_vals[0] = 12'd5;
    lane_vals[1] = 12'd10;
    lane_vals[2] = 12'd0;
    lane_vals[3] = 12'd7;
    for (int b = 0; b < 4; b++) begin
      t = tile_p(12'd1);
      t[19*12 +: 12] = lane_vals[b];
      if (b == 3) begin
        @(negedge clk);
        chk("bubble_no_early_valid", {31'b0, sum_valid}, 32'd0);
        @(posedge clk); #1;
      end
      beat(t, 8'd4);
      if (b < 3) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("latency_valid_t1", {31'b0, sum_valid}, 32'd1);
    ea20 = tile_20(4);
    ea20[19*20 +: 20] = 20'd22;
    ea16 = tile_16(4);
    ea16[19*16 +: 16] = 16'd22;
    chk("bubble_lane19", {12'b0, sum20[19*20 +: 20]}, 32'd22);
    e.s20 = ea20;
    e.o20 = 1'b0;
    e.s16 = ea16;
    e.o16 = 1'b0;
    sb.push_back(e);

    // Back-pressure: new beat offered while held tile is stalled
    @(posedge clk); #1;
    prod       = tile_p(12'd3);
    acc_len    = 8'd1;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_prod_ready_low", {31'b0, prod_ready}, 32'd0);
      chk("bp_sum_stable", {31'b0, (sum20 === ea20) && sum_valid}, 32'd1);
      @(posedge clk); #1;
    end
    sb.push_back(mk_exp(3, 1'b0, 3, 1'b0));
    sum_ready = 1'b1;
    beat(tile_p(12'd3), 8'd1);
    @(negedge clk);
    chk("bp_no_bubble_valid", {31'b0, sum_valid}, 32'd1);
    @(posedge clk); #1;
    drain("bp_drain");

    // Streaming L=2 over 20 incrementing beats
    for (int k = 0; k < 10; k++) sb.push_back(mk_exp(4*k + 1, 1'b0, 4*k + 1, 1'b0));
    t0 = cyc;
    for (int n = 0; n < 20; n++) beat(tile_p(12'(n)), 8'd2);
    chk("stream_cycles", 32'(cyc - t0), 32'd20);
    drain("stream_drain");

    // Reset mid-ACCUM discards partial sum
    beat(tile_p(12'd5), 8'd4);
    beat(tile_p(12'd5), 8'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_prod_ready", {31'b0, prod_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cleared", {31'b0, (sum20 === '0) && !sum_valid && !overflow}, 32'd1);
    @(posedge clk); #1;
    sb.push_back(mk_exp(9, 1'b0, 9, 1'b0));
    beat(tile_p(12'd9), 8'd1);
    drain("midrst_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sits directly downstream of the registered multiplier array; consumes one DIM_C x DIM_A product tile per accepted beat.
- Accumulates a runtime-programmed number of tiles (temporal reduction over K) into per-lane unsigned sums.
- Presents each finished sum tile on a valid/ready output port for the writeback stage.
- One output tile is held and can be drained while the next group's first beat is accepted.

Parameters:
- DIM_A, 16, rows per tile (matches multiplier A dimension)
- DIM_C, 4, columns per tile (matches multiplier C dimension)
- ACC_WIDTH, 12, width of each unsigned product lane
- SUM_WIDTH, 20, width of each accumulated lane; must be >= ACC_WIDTH
- LEN_W, 8, width of acc_len

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- prod  in  DIM_C*DIM_A*ACC_WIDTH  product tile, lane index c*DIM_A+a, unsigned
- prod_valid  in  1  prod is valid this cycle
- prod_ready  out  1  block accepts prod this cycle
- acc_len  in  LEN_W  number of beats per group; sampled on the first beat of a group
- sum  out  DIM_C*DIM_A*SUM_WIDTH  accumulated tile, same lane ordering
- sum_valid  out  1  sum holds a finished group
- sum_ready  in  1  consumer takes sum this cycle
- overflow  out  1  at least one lane of the current sum saturated; valid with sum_valid

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset state:
  - state=IDLE, all sum lanes 0, sum_valid=0, overflow=0, beat counter 0, latched length 0.
  - prod_ready=0 during the reset cycle and 1 in the first cycle after reset.
  - Reset asserted mid-group or mid-HOLD discards all partial and held data with no output beat.
- Acceptance: prod is accepted when prod_valid && prod_ready. Output transfer occurs when sum_valid && sum_ready.
- Length handling: the length is latched from acc_len on the first beat of a group. A value of 0 is treated as 1. Changes to acc_len mid-group are ignored.
- States:
  - IDLE:
    - prod_ready=1, sum_valid=0.
    - On accept: sum lanes <= zero-extended prod; overflow <= 0; count <= 1; latch length L.
    - If L==1, go to HOLD; otherwise go to ACCUM.
  - ACCUM:
    - prod_ready=1, sum_valid=0.
    - On accept: each lane <= sat(lane + prod_lane); count++.
    - When the accepted beat is the L-th, go to HOLD.
    - No accept leaves state and sums unchanged (bubbles allowed).
  - HOLD:
    - sum_valid=1; sum and overflow stable until transfer; prod_ready = sum_ready (combinational).
    - Transfer with no accept: go to IDLE.
    - Transfer with a simultaneous accept: the beat starts a new group exactly as in IDLE, going to ACCUM, or to HOLD if L==1, with sum_valid staying 1 for the new group next cycle.
    - prod_valid while sum_ready=0 is not accepted.
- Arithmetic:
  - Unsigned.
  - sat(x) = min(x, 2^SUM_WIDTH-1) per lane.
  - Any lane saturating sets overflow sticky for the group; it clears on the first beat of the next group.
- Latency: the L-th accepted beat at cycle t gives sum_valid=1 at t+1.
- Throughput: with sum_ready tied high, one beat per cycle sustained and no bubbles between groups.
- Outputs are registered except prod_ready, which is combinational from state and sum_ready.

Test Plan:
- Reset then L=1, all lanes of prod = 12'hFFF with valid 1 cycle -> next cycle sum_valid=1, every lane = 20'h00FFF, overflow=0; sum_ready=1 -> IDLE.
- L=4, lane a=3,c=1 fed 5,10,0,7 with one-cycle bubbles between beats, other lanes 1 -> sum lane(1,3)=22, others 4, sum_valid exactly one cycle after the 4th accept.
- L=255, all lanes 12'hFFF (sum 1044225 > 1048575? no) repeat with SUM_WIDTH=16 build: after 17 beats saturate -> every lane 16'hFFFF, overflow=1; next group L=1 prod=1 -> lane=1, overflow=0.
- Back-pressure: group done, sum_ready=0 for 5 cycles with prod_valid=1 -> prod_ready=0, sum stable; then sum_ready=1 -> same-cycle accept of new group's first beat, no bubble.
- Streaming L=2, prod_valid and sum_ready held 1 over 20 beats of incrementing values n -> 10 output groups, group k = (2k)+(2k+1), one output every 2 cycles.
- Reset asserted mid-ACCUM (after 2 of 4 beats), then L=1 prod=9 -> sum lanes = 9, no stale partial sum, and no output beat before it.
